uart_tx_param: RTL and testbench

//   Parametrised UART transmitter with an internal TX FIFO. Accepts words over
//   a valid/ready stream handshake, buffers up to FIFO_DEPTH words, and sends

---
 rtl/uart_tx_param.sv | 128 ++++++++++++
 tb/tb_uart_tx_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with configurable data width, parity and stop bits
module uart_tx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          s_ready,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int TICKS = CLK_FREQ / BAUD_RATE;
  localparam int TW    = $clog2(TICKS);
  localparam int PW    = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, head;
  logic                 par_q, par_d, tx_q, tx_d, done_q, done_d;
  logic [PW-1:0]        wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]          count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic                 push, pop, tick_end;
  assign s_ready    = int'(count_q) < FIFO_DEPTH;
  assign push       = s_valid && s_ready;
  assign head       = mem_q[rp_q];
  assign tick_end   = timer_q == TW'(TICKS - 1);
  assign tx_out     = tx_q;
  assign tx_busy    = state_q != IDLE;
  assign tx_done    = done_q;
  assign fifo_count = count_q;
  always_comb begin
    state_d = state_q;
    timer_d = tick_end ? '0 : timer_q + 1'b1;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        pop     = count_q != '0;
      end
      START: if (tick_end) begin
        state_d = DATA;
        tx_d    = sh_q[0];
        cnt_d   = '0;
      end
      DATA: if (tick_end) begin
        if (cnt_q == 4'(DATA_BITS - 1)) begin
          state_d = (PARITY != 0) ? PAR : STOP;
          tx_d    = (PARITY != 0) ? par_q : 1'b1;
          cnt_d   = '0;
        end else begin
          sh_d  = sh_q >> 1;
          tx_d  = sh_q[1];
          cnt_d = cnt_q + 1'b1;
        end
      end
      PAR: if (tick_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (tick_end) begin
        if (cnt_q == 4'(STOP_BITS - 1)) begin
          done_d  = 1'b1;
          pop     = count_q != '0;
          state_d = IDLE;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // a pop always starts a new frame, whether from IDLE or straight out of STOP
    if (pop) begin
      state_d = START;
      sh_d    = head;
      par_d   = (PARITY == 2) ? ~^head : ^head;
      tx_d    = 1'b0;
      timer_d = '0;
    end
  end
  assign wp_d    = push ? wp_q + 1'b1 : wp_q;
  assign rp_d    = pop ? rp_q + 1'b1 : rp_q;
  assign count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= s_data;
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench decoding the serial line of three differently configured transmitters
module tb_uart_tx_param;
  localparam int T = 10;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic       sv   [3];
  logic [8:0] sd   [3];
  logic       rdy  [3];
  logic       tx   [3];
  logic       busy [3];
  logic       done [3];
  logic [2:0] cnt  [3];
  logic [8:0] msk  [3];
  int q [3][$];
  int b2b [3];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .reset(reset), .s_valid(sv[0]), .s_data(sd[0][7:0]), .s_ready(rdy[0]),
    .tx_out(tx[0]), .tx_busy(busy[0]), .tx_done(done[0]), .fifo_count(cnt[0]));
  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .reset(reset), .s_valid(sv[1]), .s_data(sd[1][6:0]), .s_ready(rdy[1]),
    .tx_out(tx[1]), .tx_busy(busy[1]), .tx_done(done[1]), .fifo_count(cnt[1]));
  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(5), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .reset(reset), .s_valid(sv[2]), .s_data(sd[2][4:0]), .s_ready(rdy[2]),
    .tx_out(tx[2]), .tx_busy(busy[2]), .tx_done(done[2]), .fifo_count(cnt[2]));

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // expected frame built from the framing rules; decoded by sampling each bit mid-period
  task automatic mon(input int i, input int db, input int par, input int sb);
    int len, w;
    bit skip, ab, bsy;
    logic [15:0] ef, gf;
    time lastend;
    len = 1 + db + ((par != 0) ? 1 : 0) + sb;
    skip = 1'b0;
    lastend = 0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (reset && tx[i] === 1'b0) begin
        if ($time == lastend) b2b[i]++;
        if (q[i].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL start_%0d: got a frame start, expected none (scoreboard empty)", i);
          w = 0;
        end else begin
          w = q[i].pop_front();
        end
        ef = '1;
        ef[0] = 1'b0;
        for (int b = 0; b < db; b++) ef[1+b] = w[b];
        if (par != 0) ef[1+db] = (par == 2) ? ~^w : ^w;
        gf = '1;
        bsy = 1'b1;
        ab = 1'b0;
        for (int k = 1; k <= len * T && !ab; k++) begin
          @(negedge clk);
          if (!reset) ab = 1'b1;
          else begin
            if (k % T == T / 2) begin
              gf[k/T] = tx[i];
              bsy &= busy[i];
            end
            if (k == len * T - 1) chk($sformatf("done_early_%0d", i), int'(done[i]), 0);
            if (k == len * T) chk($sformatf("done_pulse_%0d", i), int'(done[i]), 1);
          end
        end
        if (!ab) begin
          chk($sformatf("frame_%0d", i), int'(gf), int'(ef));
          chk($sformatf("busy_in_frame_%0d", i), int'(bsy), 1);
          lastend = $time;
          skip = 1'b1;
        end
      end
    end
  endtask

  task automatic push(input int i, input logic [8:0] w, output int stalls);
    stalls = 0;
    @(negedge clk);
    sv[i] = 1'b1;
    sd[i] = w & msk[i];
    while (!rdy[i] && stalls < 2000) begin
      @(negedge clk);
      stalls++;
    end
    if (!rdy[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout_%0d: got s_ready=0 after %0d cycles, expected acceptance", i, stalls);
      sv[i] = 1'b0;
    end else begin
      @(posedge clk);
      q[i].push_back(int'(w & msk[i]));
      #1 sv[i] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    bit idle;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      idle = 1'b1;
      for (int i = 0; i < 3; i++)
        if (q[i].size() != 0 || busy[i] || cnt[i] != 0) idle = 1'b0;
    end while (!idle && n < 10000);
    if (!idle) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic rnd(input int i, input int n);
    int st;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      push(i, 9'($urandom_range(0, 511)), st);
    end
  endtask

  initial fork
    mon(0, 8, 1, 1);
    mon(1, 7, 2, 2);
    mon(2, 5, 0, 1);
  join

  initial begin
    int st, b0;
    time n0;
    msk[0] = 9'h0FF;
    msk[1] = 9'h07F;
    msk[2] = 9'h01F;
    for (int i = 0; i < 3; i++) begin
      sv[i] = 1'b0;
      sd[i] = '0;
      b2b[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx_%0d", i), int'(tx[i]), 1);
      chk($sformatf("rst_busy_%0d", i), int'(busy[i]), 0);
      chk($sformatf("rst_done_%0d", i), int'(done[i]), 0);
      chk($sformatf("rst_count_%0d", i), int'(cnt[i]), 0);
      chk($sformatf("rst_ready_%0d", i), int'(rdy[i]), 1);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    push(1, 9'h041, st);
    push(2, 9'h01F, st);
    push(0, 9'h0A5, st);
    @(negedge clk);
    chk("lat_tx_before", int'(tx[0]), 1);
    chk("lat_count_before", int'(cnt[0]), 1);
    @(negedge clk);
    n0 = $time;
    chk("lat_tx_start", int'(tx[0]), 0);
    chk("lat_count_pop", int'(cnt[0]), 0);
    chk("lat_busy", int'(busy[0]), 1);
    push(0, 9'h0C3, st);
    push(0, 9'h05A, st);
    while ($time < n0 + (11 * T - 1) * 10) @(negedge clk);
    chk("pp_count_before", int'(cnt[0]), 2);
    sv[0] = 1'b1;
    sd[0] = 9'h096;
    @(posedge clk);
    q[0].push_back(32'h96);
    #1 sv[0] = 1'b0;
    @(negedge clk);
    chk("pp_count_after", int'(cnt[0]), 2);
    chk("pp_done", int'(done[0]), 1);
    wait_idle();
    b0 = b2b[0];
    push(0, 9'h011, st);
    for (int k = 0; k < 4; k++) push(0, 9'($urandom_range(0, 255)), st);
    @(negedge clk);
    chk("full_count", int'(cnt[0]), 4);
    chk("full_ready", int'(rdy[0]), 0);
    push(0, 9'h0EE, st);
    chk("full_stalled", int'(st > 0), 1);
    @(negedge clk);
    chk("full_count_refill", int'(cnt[0]), 4);
    wait_idle();
    chk("b2b_frames", b2b[0] - b0, 5);
    fork
      rnd(0, 12);
      rnd(1, 12);
      rnd(2, 12);
    join
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      push(i, 9'($urandom_range(0, 511)), st);
      push(i, 9'($urandom_range(0, 511)), st);
    end
    repeat (25) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) q[i].delete();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_tx_%0d", i), int'(tx[i]), 1);
      chk($sformatf("abort_busy_%0d", i), int'(busy[i]), 0);
      chk($sformatf("abort_count_%0d", i), int'(cnt[i]), 0);
      chk($sformatf("abort_ready_%0d", i), int'(rdy[i]), 1);
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) push(i, 9'h03C, st);
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
